pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Fetch-side controller that owns the program counter register and sequences instruction fetch for the RV32I core. It issues one request at a time to instruction memory and hands each fetched word, with its PC, to decode through a valid/ready handshake. Next-PC selection is trap vector, then redirect target (branch/jump), then PC+4. It replaces the free-running PC update so that memory wait states, decode stalls, redirects and halt are handled in one place.

Parameters:
RESET_VEC  32'h0000_0000  PC loaded on reset
TRAP_VEC   32'h0000_0100  PC loaded on trap or misaligned redirect

Ports:
clk             in   1   clock
reset           in   1   reset, asynchronous, active-high
imem_req        out  1   fetch request valid
imem_addr       out  32  fetch address (word aligned)
imem_gnt        in   1   memory accepts the request this cycle
imem_rvalid     in   1   read data valid (one pulse per granted request)
imem_rdata      in   32  instruction word
instr_valid     out  1   instruction available to decode
instr           out  32  instruction word
instr_pc        out  32  PC of instr
instr_ready     in   1   decode accepts instr
redirect_valid  in   1   branch/jump taken, 1-cycle pulse
redirect_pc     in   32  redirect target
trap            in   1   exception, 1-cycle pulse
halt_req        in   1   stop fetching (level)
halted          out  1   sequencer in HALT
misaligned_err  out  1   1-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (async): pc=RESET_VEC, state=REQ, kill=0, instr_valid=0, instr=0, instr_pc=0, halted=0, misaligned_err=0. imem_req is decoded from state, so it is high in the first cycle after reset.
- States: REQ, WAIT, HOLD, HALT. At most one request is outstanding.
- REQ: imem_req=1, imem_addr=pc. On imem_gnt, go to WAIT. If halt_req=1 and gnt=0, go to HALT and drop the request.
- WAIT: imem_req=0. On imem_rvalid with kill=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to HOLD. On imem_rvalid with kill=1: discard the data, clear kill, go to REQ.
- HOLD: instr_valid, instr and instr_pc are held stable. On instr_ready: instr_valid<=0 and pc<=pc+4. Then go to HALT if halt_req=1, otherwise go to REQ.
- Best-case throughput is one instruction per 3 cycles: REQ with gnt, WAIT with rvalid, HOLD with ready.
- Next-PC priority, evaluated every cycle in any state: trap > redirect_valid > sequential.
  - trap: pc<=TRAP_VEC.
  - redirect: pc<=redirect_pc. If redirect_pc[1:0]!=0, treat it as a trap: pc<=TRAP_VEC and pulse misaligned_err.
- Redirect/trap handling by state:
  - REQ without gnt: imem_addr shows the new pc the next cycle and imem_req stays high. This is the only case in which an ungranted address may change.
  - REQ with gnt in the same cycle: that request is stale. Set kill=1 and go to WAIT.
  - WAIT: set kill=1. The response is still awaited and discarded.
  - HOLD: instr_valid<=0 (instruction squashed, ready ignored), then go to REQ.
  - HALT: leave halt, halted<=0, go to REQ with the new pc. halt_req is ignored that cycle.
- HALT: imem_req=0, instr_valid=0, halted=1. Exit only via trap, redirect or reset.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. pc[1:0] is always 0.
- Reset mid-transaction: state returns to REQ immediately. An rvalid arriving after reset while in REQ is ignored.

Optional Feature:
PC_FETCH_PERF_EN
- Defined: adds output fetch_count[31:0]. It increments on each HOLD handshake (instr_valid & instr_ready, not squashed), resets to 0, and wraps at 2^32.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release, gnt=1 and rvalid next cycle with rdata=32'h00500093, ready=1 -> imem_addr=0, instr_pc=0, then next imem_addr=4; a second fetch gives instr_pc=4.
- gnt held 0 for 3 cycles, then rvalid delayed 2 cycles, ready low 4 cycles -> imem_req held and addr stable; instr/instr_pc stable in HOLD; pc advances by exactly 4.
- redirect_valid with redirect_pc=32'h0000_0200 during WAIT -> the returning rdata is never presented (instr_valid stays 0); next imem_addr=0x200.
- trap and redirect in the same cycle (redirect_pc=0x300) -> next imem_addr=TRAP_VEC (0x100).
- redirect_pc=32'h0000_0202 -> misaligned_err high exactly 1 cycle; next imem_addr=0x100.
- Sequence and halt:
  - pc=0xFFFF_FFFC with handshake -> next imem_addr=0.
  - halt_req in HOLD with ready -> halted=1, no imem_req; a later redirect to 0x40 -> halted=0 and imem_addr=0x40.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Fetch-side controller for the RV32I core. It owns the program counter,
// issues one instruction-memory request at a time and hands each fetched
// word (with its PC) to decode through a valid/ready handshake.
//
// The next PC is chosen in this order: trap vector, then redirect target,
// then PC+4. A misaligned redirect target is treated as a trap.
//
// Optional feature macro: PC_FETCH_PERF_EN
//   When defined, the block adds the output fetch_count[31:0]. This counter
//   counts the instructions accepted by decode. It resets to 0 and wraps.
//
// Ports:
//   clk, reset       clock; asynchronous active-high reset
//   imem_req/addr    fetch request and word-aligned address (decoded from state/pc)
//   imem_gnt         memory accepts the request this cycle
//   imem_rvalid/rdata  read response (one pulse per granted request)
//   instr_valid/instr/instr_pc  instruction to decode, held until accepted
//   instr_ready      decode accepts the instruction
//   redirect_valid/redirect_pc  taken branch/jump (1-cycle pulse)
//   trap             exception (1-cycle pulse)
//   halt_req         stop fetching (level)
//   halted           sequencer is in HALT
//   misaligned_err   1-cycle pulse on a redirect target with pc[1:0] != 0
//   fetch_count      (PC_FETCH_PERF_EN only) accepted-instruction count
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    input  logic        halt_req,
    output logic        halted,
`ifdef PC_FETCH_PERF_EN
    output logic [31:0] fetch_count,
`endif
    output logic        misaligned_err
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        kill_q;
    logic        instr_valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        halted_q;
    logic        misaligned_err_q;

    // Control-flow change requested this cycle and the PC it selects.
    logic        flow_chg;
    logic        misaligned;
    logic [31:0] flow_pc_d;

    always_comb begin
        misaligned = redirect_valid && !trap && (redirect_pc[1:0] != 2'b00);
        flow_chg   = trap || redirect_valid;
        if (trap || misaligned) begin
            flow_pc_d = TRAP_VEC;
        end else begin
            flow_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_REQ;
            pc_q             <= RESET_VEC;
            kill_q           <= 1'b0;
            instr_valid_q    <= 1'b0;
            instr_q          <= 32'h0;
            instr_pc_q       <= 32'h0;
            halted_q         <= 1'b0;
            misaligned_err_q <= 1'b0;
        end else begin
            misaligned_err_q <= misaligned;
            if (flow_chg) begin
                pc_q <= flow_pc_d;
            end

            case (state_q)
                S_REQ: begin
                    if (imem_gnt) begin
                        // A grant in the same cycle as a flow change
                        // fetches from the old PC, so its response is dropped.
                        state_q <= S_WAIT;
                        kill_q  <= flow_chg;
                    end else if (halt_req && !flow_chg) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q || flow_chg) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            instr_q       <= imem_rdata;
                            instr_pc_q    <= pc_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= S_HOLD;
                        end
                    end else if (flow_chg) begin
                        kill_q <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (flow_chg) begin
                        // Squash: the held instruction is on the wrong path.
                        instr_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                    end else if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= pc_q + 32'd4;
                        if (halt_req) begin
                            state_q  <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                end

                S_HALT: begin
                    if (flow_chg) begin
                        halted_q <= 1'b0;
                        state_q  <= S_REQ;
                    end
                end

                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

`ifdef PC_FETCH_PERF_EN
    logic [31:0] fetch_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'h0;
        end else if (state_q == S_HOLD && instr_valid_q && instr_ready && !flow_chg) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

    assign imem_req       = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign halted         = halted_q;
    assign misaligned_err = misaligned_err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic        halt_req;
    logic        halted;
    logic        misaligned_err;
`ifdef PC_FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    pc_fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap           (trap),
        .halt_req       (halt_req),
        .halted         (halted),
`ifdef PC_FETCH_PERF_EN
        .fetch_count    (fetch_count),
`endif
        .misaligned_err (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        trap           = 1'b0;
        halt_req       = 1'b0;

        // Reset state
        #1;
        chk("rst_req",   {31'b0, imem_req},       32'd1);
        chk("rst_addr",  imem_addr,               32'h0);
        chk("rst_valid", {31'b0, instr_valid},    32'd0);
        chk("rst_instr", instr,                   32'h0);
        chk("rst_ipc",   instr_pc,                32'h0);
        chk("rst_halt",  {31'b0, halted},         32'd0);
        chk("rst_mis",   {31'b0, misaligned_err}, 32'd0);
        #2 reset = 1'b0;

        // First fetch at 0, best-case 3 cycles
        imem_gnt = 1'b1;
        cyc();
        chk("f1_wait_req", {31'b0, imem_req}, 32'd0);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        cyc();
        chk("f1_valid", {31'b0, instr_valid}, 32'd1);
        chk("f1_instr", instr,                32'h0050_0093);
        chk("f1_ipc",   instr_pc,             32'h0);
        imem_rvalid = 1'b0; instr_ready = 1'b1;
        cyc();
        chk("f1_next_addr", imem_addr,            32'h4);
        chk("f1_next_req",  {31'b0, imem_req},    32'd1);
        chk("f1_drop",      {31'b0, instr_valid}, 32'd0);

        // Second fetch gives pc 4
        instr_ready = 1'b0; imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        cyc();
        chk("f2_ipc",   instr_pc, 32'h4);
        chk("f2_instr", instr,    32'h1234_5678);
        imem_rvalid = 1'b0; instr_ready = 1'b1;
        cyc();
        chk("f2_next_addr", imem_addr, 32'h8);
        instr_ready = 1'b0;

        // Wait states: no grant for 3 cycles, late rvalid, decode stall
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ws_req_held", {31'b0, imem_req}, 32'd1);
            chk("ws_addr_stable", imem_addr, 32'h8);
        end
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("ws_no_valid", {31'b0, instr_valid}, 32'd0);
        end
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_5555;
        cyc();
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ws_hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("ws_hold_instr", instr,    32'hAAAA_5555);
            chk("ws_hold_ipc",   instr_pc, 32'h8);
            chk("ws_hold_noreq", {31'b0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        cyc();
        chk("ws_pc_plus4", imem_addr, 32'hC);
        instr_ready = 1'b0;

        // Redirect during WAIT: response is discarded
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cyc();
        redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_rvalid = 1'b0;
        chk("kill_no_valid", {31'b0, instr_valid}, 32'd0);
        chk("kill_req",      {31'b0, imem_req},    32'd1);
        chk("kill_addr",     imem_addr,            32'h200);
        cyc();
        chk("kill_no_valid2", {31'b0, instr_valid}, 32'd0);

        // Trap beats redirect in the same cycle (REQ without grant)
        trap = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        cyc();
        trap = 1'b0; redirect_valid = 1'b0;
        chk("trap_prio_addr", imem_addr, 32'h100);
        chk("trap_prio_req",  {31'b0, imem_req}, 32'd1);

        // Misaligned redirect goes to the trap vector and pulses once
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
        cyc();
        redirect_valid = 1'b0;
        chk("mis_pulse", {31'b0, misaligned_err}, 32'd1);
        chk("mis_addr",  imem_addr,               32'h100);
        cyc();
        chk("mis_pulse_end", {31'b0, misaligned_err}, 32'd0);

        // PC+4 wraps at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        cyc();
        imem_rvalid = 1'b0;
        chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("wrap_next", imem_addr, 32'h0);

        // Halt after a handshake, exit by redirect
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0033;
        cyc();
        imem_rvalid = 1'b0; instr_ready = 1'b1; halt_req = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("halt_flag",  {31'b0, halted},      32'd1);
        chk("halt_noreq", {31'b0, imem_req},    32'd0);
        chk("halt_noval", {31'b0, instr_valid}, 32'd0);
        cyc();
        cyc();
        chk("halt_stays", {31'b0, halted},   32'd1);
        chk("halt_stays_noreq", {31'b0, imem_req}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        cyc();
        redirect_valid = 1'b0; halt_req = 1'b0;
        chk("unhalt_flag", {31'b0, halted},   32'd0);
        chk("unhalt_req",  {31'b0, imem_req}, 32'd1);
        chk("unhalt_addr", imem_addr,         32'h40);

        // Redirect in HOLD squashes the instruction; ready is ignored
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0063;
        cyc();
        imem_rvalid = 1'b0;
        chk("sq_valid", {31'b0, instr_valid}, 32'd1);
        chk("sq_ipc",   instr_pc,             32'h40);
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
        cyc();
        instr_ready = 1'b0; redirect_valid = 1'b0;
        chk("sq_drop", {31'b0, instr_valid}, 32'd0);
        chk("sq_addr", imem_addr,            32'h80);
        chk("sq_req",  {31'b0, imem_req},    32'd1);

        // Halt from REQ without grant, exit by trap
        halt_req = 1'b1;
        cyc();
        chk("reqhalt_flag",  {31'b0, halted},   32'd1);
        chk("reqhalt_noreq", {31'b0, imem_req}, 32'd0);
        trap = 1'b1;
        cyc();
        trap = 1'b0; halt_req = 1'b0;
        chk("trapexit_flag", {31'b0, halted}, 32'd0);
        chk("trapexit_addr", imem_addr,       32'h100);

        // Reset mid-transaction returns to REQ; a later rvalid is ignored
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_req",  {31'b0, imem_req}, 32'd1);
        chk("mid_rst_addr", imem_addr,         32'h0);
        #1 reset = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        cyc();
        imem_rvalid = 1'b0;
        chk("mid_rst_noval", {31'b0, instr_valid}, 32'd0);
        chk("mid_rst_req2",  {31'b0, imem_req},    32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
